// File: rtl/cam_i2c_byte_writer.sv
// cam_i2c_byte_writer: turns a stream of 3-byte register-write groups
// (reg addr, data hi, data lo) into I2C write frames to one of two sensors.
// Byte intake handshake: a byte moves on a rising sysClk edge where
// byte_valid and byte_ready are both 1; byte_ready is only offered in IDLE,
// LOAD and DISCARD, and a producer seeing byte_ready=0 keeps byte_in stable.
module cam_i2c_byte_writer #(
   parameter int         CLK_DIV       = 125,
   parameter logic [6:0] DEV_ADDR_CAM0 = 7'h5D,
   parameter logic [6:0] DEV_ADDR_CAM1 = 7'h48
) (
   input  logic       sysClk,
   input  logic       rst_n,
   input  logic [7:0] byte_in,
   input  logic       byte_valid,
   output logic       byte_ready,
   input  logic       last_group,
   input  logic       cam_id,
   output logic       scl_oe,
   output logic       sda_oe,
   input  logic       sda_in,
   output logic       busy,
   output logic       done,
   output logic       nack_err,
   output logic [2:0] fsm_state
);

   localparam int DIV_W = $clog2(CLK_DIV);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_START   = 3'd1,
      S_LOAD    = 3'd2,
      S_SHIFT   = 3'd3,
      S_ACK     = 3'd4,
      S_STOP    = 3'd5,
      S_DISCARD = 3'd6
   } state_t;

   state_t           state;
   logic [DIV_W-1:0] div_cnt;
   logic [1:0]       q;          // quarter of the current SCL bit
   logic [2:0]       bit_cnt;
   logic [7:0]       shreg;
   logic [7:0]       reg_addr;
   logic [1:0]       byte_idx;   // 0 device, 1 reg addr, 2 data hi, 3 data lo
   logic [1:0]       drop_cnt;   // bytes still to swallow after a NACK
   logic             last_reg;
   logic             nack_flag;
   logic             tick;

   assign tick      = (div_cnt == DIV_W'(CLK_DIV - 1));
   assign fsm_state = state;

   // Single FSM: quarter timing, bit shifting, handshake and status pulses.
   always_ff @(posedge sysClk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         div_cnt    <= '0;
         q          <= 2'd0;
         bit_cnt    <= 3'd0;
         shreg      <= 8'h00;
         reg_addr   <= 8'h00;
         byte_idx   <= 2'd0;
         drop_cnt   <= 2'd0;
         last_reg   <= 1'b0;
         nack_flag  <= 1'b0;
         byte_ready <= 1'b0;
         scl_oe     <= 1'b0;
         sda_oe     <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         nack_err   <= 1'b0;
      end else begin
         done     <= 1'b0;
         nack_err <= 1'b0;
         // ticking states advance div_cnt; waiting states hold it at zero so
         // every state entry starts a fresh quarter
         if (state == S_IDLE || state == S_LOAD || state == S_DISCARD || tick)
            div_cnt <= '0;
         else
            div_cnt <= div_cnt + 1'b1;

         case (state)
            S_IDLE: begin
               scl_oe <= 1'b0;
               sda_oe <= 1'b0;
               q      <= 2'd0;
               if (byte_ready && byte_valid) begin
                  reg_addr   <= byte_in;
                  last_reg   <= last_group;
                  shreg      <= {(cam_id ? DEV_ADDR_CAM1 : DEV_ADDR_CAM0), 1'b0};
                  byte_idx   <= 2'd0;
                  nack_flag  <= 1'b0;
                  busy       <= 1'b1;
                  byte_ready <= 1'b0;
                  state      <= S_START;
               end else begin
                  byte_ready <= 1'b1;
               end
            end

            // q0 both released, q1..q2 SDA low under high SCL, then SCL low
            S_START: if (tick) begin
               case (q)
                  2'd0:    begin sda_oe <= 1'b1; q <= 2'd1; end
                  2'd1:    q <= 2'd2;
                  default: begin
                     scl_oe  <= 1'b1;
                     sda_oe  <= ~shreg[7];
                     q       <= 2'd0;
                     bit_cnt <= 3'd0;
                     state   <= S_SHIFT;
                  end
               endcase
            end

            // SCL held low until the producer supplies the next data byte
            S_LOAD: begin
               if (byte_ready && byte_valid) begin
                  shreg      <= byte_in;
                  sda_oe     <= ~byte_in[7];
                  byte_ready <= 1'b0;
                  byte_idx   <= byte_idx + 2'd1;
                  bit_cnt    <= 3'd0;
                  q          <= 2'd0;
                  state      <= S_SHIFT;
               end
            end

            S_SHIFT: if (tick) begin
               q <= q + 2'd1;
               if (q == 2'd1) scl_oe <= 1'b0;
               if (q == 2'd3) begin
                  scl_oe <= 1'b1;
                  if (bit_cnt == 3'd7) begin
                     sda_oe <= 1'b0;
                     state  <= S_ACK;
                  end else begin
                     bit_cnt <= bit_cnt + 3'd1;
                     shreg   <= {shreg[6:0], 1'b0};
                     sda_oe  <= ~shreg[6];
                  end
               end
            end

            // 9th clock: SDA released, slave answer sampled at the end of q2
            S_ACK: if (tick) begin
               q <= q + 2'd1;
               if (q == 2'd1) scl_oe <= 1'b0;
               if (q == 2'd2 && sda_in) begin
                  nack_flag <= 1'b1;
                  nack_err  <= 1'b1;
                  drop_cnt  <= (byte_idx == 2'd3) ? 2'd0 :
                               (byte_idx == 2'd2) ? 2'd1 : 2'd2;
               end
               if (q == 2'd3) begin
                  scl_oe <= 1'b1;
                  if (nack_flag || byte_idx == 2'd3) begin
                     sda_oe <= 1'b1;
                     state  <= S_STOP;
                  end else if (byte_idx == 2'd0) begin
                     shreg    <= reg_addr;
                     sda_oe   <= ~reg_addr[7];
                     byte_idx <= 2'd1;
                     bit_cnt  <= 3'd0;
                     state    <= S_SHIFT;
                  end else begin
                     byte_ready <= 1'b1;
                     state      <= S_LOAD;
                  end
               end
            end

            // q0 SDA low/SCL low, q1 SCL released, q2 SDA released
            S_STOP: if (tick) begin
               q <= q + 2'd1;
               if (q == 2'd0) scl_oe <= 1'b0;
               if (q == 2'd1) sda_oe <= 1'b0;
               if (q == 2'd2) begin
                  q          <= 2'd0;
                  byte_ready <= 1'b1;
                  if (nack_flag && drop_cnt != 2'd0) begin
                     state <= S_DISCARD;
                  end else begin
                     state <= S_IDLE;
                     if (last_reg) begin
                        busy <= 1'b0;
                        done <= ~nack_flag;
                     end
                  end
               end
            end

            // swallow the rest of a NACKed group without touching the bus
            S_DISCARD: begin
               if (byte_ready && byte_valid) begin
                  if (drop_cnt == 2'd1) begin
                     state <= S_IDLE;
                     if (last_reg) busy <= 1'b0;
                  end
                  drop_cnt <= drop_cnt - 2'd1;
               end
            end

            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: doc/cam_i2c_byte_writer.md
CAM_I2C_BYTE_WRITER -- requirements
Module: cam_i2c_byte_writer

Interface
REQ-001 SHALL have parameter CLK_DIV, default 125, meaning sysClk cycles per SCL quarter-period (min 2).
REQ-002 SHALL have parameter DEV_ADDR_CAM0, default 7'h5D, meaning 7-bit sensor address used when cam_id=0.
REQ-003 SHALL have parameter DEV_ADDR_CAM1, default 7'h48, meaning 7-bit sensor address used when cam_id=1.
REQ-004 SHALL have port sysClk  in  1  system clock; all logic on rising edge.
REQ-005 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port byte_in  in  8  next byte of the register-write stream (reg addr, data hi, data lo, repeating).
REQ-007 SHALL have port byte_valid  in  1  byte_in holds a valid byte.
REQ-008 SHALL have port byte_ready  out  1  block accepts byte_in this cycle; transfer = byte_valid & byte_ready.
REQ-009 SHALL have port last_group  in  1  sampled with each group's first byte; marks the final 3-byte group of a command.
REQ-010 SHALL have port cam_id  in  1  target sensor select, sampled with each group's first byte.
REQ-011 SHALL have ports scl_oe, sda_oe  out  1 each  open-drain drive; 1 pulls the line low, 0 releases it.
REQ-012 SHALL have port sda_in  in  1  sampled SDA line level.
REQ-013 SHALL have ports busy, done, nack_err  out  1 each  transaction active; 1-cycle pulse after final STOP; 1-cycle pulse on any NACK.

Function
REQ-014 SHALL generate a tick every CLK_DIV sysClk cycles while not IDLE; each SCL bit = 4 ticks: q0,q1 SCL low (SDA changes at q0), q2,q3 SCL released.
REQ-015 SHALL use states IDLE, START, LOAD, SHIFT, ACK, STOP, in that order of use.
REQ-016 IDLE: byte_ready=1, SCL/SDA released; on transfer, latch byte_in, cam_id and last_group, then go to START.
REQ-017 START: SDA released for 1 tick, SDA low with SCL released for 2 ticks, then SCL low; then SHIFT the device byte {DEV_ADDR,1'b0}.
REQ-018 SHIFT: 8 bits MSB first; SHALL then go to ACK, releasing SDA for the 9th clock.
REQ-019 ACK: sample sda_in at the end of q2; low = ACK, high = NACK.
REQ-020 After an ACK, SHALL shift the latched register-address byte, then enter LOAD for data hi and data lo.
REQ-021 LOAD: byte_ready=1 for exactly the cycles it waits; SCL held low (bus stall) until a transfer; then SHIFT.
REQ-022 After the 3rd byte's ACK, SHALL go to STOP: SDA low, SCL released 1 tick, then SDA released 1 tick.
REQ-023 After STOP, if last_group=0, SHALL go to IDLE with busy held at 1; if last_group=1, SHALL pulse done and clear busy.
REQ-024 On NACK, SHALL pulse nack_err, issue STOP, and accept-and-discard the group's remaining bytes (byte_ready=1, no bus activity) so the producer never stalls; no done pulse.
REQ-025 byte_ready SHALL never be 1 outside IDLE, LOAD, or discard.
REQ-026 A byte_valid arriving in any other state SHALL be held by the producer; the block ignores it without loss.
REQ-027 The tick counter SHALL restart at every state entry; no wrap artifacts at CLK_DIV boundaries.

Reset
REQ-028 rst_n low SHALL immediately drive state=IDLE, scl_oe=0, sda_oe=0, byte_ready=0, busy=0, done=0, nack_err=0, and clear all counters, including mid-byte.
REQ-029 SHALL assert byte_ready=1 on the first sysClk edge after rst_n deasserts.

Verification
REQ-030 CLK_DIV=4, cam_id=0, last_group=1, bytes 09,01,2C, slave ACKs all -> SDA shows BA,09,01,2C each followed by an ACK slot, STOP, one done pulse, 3 transfers, bit period 16 cycles.
REQ-031 Same stimulus with cam_id=1 -> first byte on SDA is 90.
REQ-032 Slave NACKs the device byte -> nack_err pulse, STOP within 2 ticks after the ACK slot, next 2 bytes accepted with no SCL toggling, no done pulse.
REQ-033 byte_valid held low 50 cycles during LOAD before data lo -> SCL low throughout, then transfer resumes with correct bits.
REQ-034 Two groups (last_group 0 then 1) -> two START/STOP frames, busy continuously 1, single done pulse.
REQ-035 rst_n pulsed low mid-SHIFT -> scl_oe=sda_oe=0 in the same cycle; the next command completes normally.
